// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready operation sequencer that drives an N-bit ALU and registers its selected result
module alu_sequencer #(
  parameter int N = 4,
  parameter int MULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [N-1:0]      a_in,
  input  logic [N-1:0]      b_in,
  input  logic              cin_in,
  input  logic [$clog2(N):0] shamt_in,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic              alu_cin,
  output logic [$clog2(N):0] alu_shamt,
  input  logic [10*N-1:0]   res_bus,
  input  logic [5:0]        cv_bus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      result,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              err,
  output logic              busy,
  output logic [7:0]        op_count
);
  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, WAIT_MUL, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op_r;
  logic [CW-1:0] cnt;
  logic accept, capture, consume, illegal, div0, c_nx, v_nx;
  logic [N-1:0] sel, res_nx;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state and the accept/capture/consume strobes
  always_comb begin
    state_nx = state;
    accept = 1'b0;
    capture = 1'b0;
    consume = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept = 1'b1;
        state_nx = (op == 4'd2 && MULT_LAT > 1) ? WAIT_MUL : EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_nx = DONE;
      end
      WAIT_MUL: if (cnt == CW'(MULT_LAT - 1)) begin
        capture = 1'b1;
        state_nx = DONE;
      end
      DONE: if (out_ready) begin
        consume = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // pick the ALU slice for the latched opcode and apply the error overrides
  always_comb begin
    illegal = op_r > 4'd9;
    div0 = (op_r == 4'd3 || op_r == 4'd4) && alu_b == '0;
    sel = res_bus[(illegal ? 0 : int'(op_r)) * N +: N];
    res_nx = illegal ? '0 : div0 ? '1 : sel;
    c_nx = op_r == 4'd0 ? cv_bus[0] : op_r == 4'd1 ? cv_bus[2] : op_r == 4'd2 ? cv_bus[4] : 1'b0;
    v_nx = op_r == 4'd0 ? cv_bus[1] : op_r == 4'd1 ? cv_bus[3] : op_r == 4'd2 ? cv_bus[5] : 1'b0;
  end
  // operand latch, multiply wait counter, result/flag capture and completion count
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_cin <= 1'b0;
      alu_shamt <= '0;
      op_r <= '0;
      cnt <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      err <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        alu_a <= a_in;
        alu_b <= b_in;
        alu_cin <= cin_in;
        alu_shamt <= shamt_in;
        op_r <= op;
        cnt <= '0;
      end else if (state == WAIT_MUL) cnt <= cnt + 1'b1;
      if (capture) begin
        result <= res_nx;
        flag_z <= res_nx == '0;
        flag_n <= res_nx[N-1];
        flag_c <= c_nx;
        flag_v <= v_nx;
        err <= illegal | div0;
      end
      if (consume) op_count <= op_count + 8'd1;
    end
  end
endmodule
